decryption: RTL and testbench

DECRYPTION -- requirements
Module: decryption

---
 rtl/cipher_pkg.sv | 22 ++
 rtl/decryption_round.sv | 13 +
 rtl/decryption.sv | 109 ++++++++++
 tb/tb_decryption.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared definitions for the character cipher blocks (encryption and decryption).
// Holds mode codes, round count, printable range limits, FSM states and the round-key helper.
package cipher_pkg;

    localparam logic [1:0] MODE_DEC   = 2'b01;
    localparam logic [1:0] MODE_ENC   = 2'b10;
    localparam int         NUM_ROUNDS = 4;
    localparam logic [7:0] PRINT_MIN  = 8'h20;
    localparam logic [7:0] PRINT_MAX  = 8'h7E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Round key: the low two counter bits replicated across the byte whiten K.
    function automatic logic [7:0] round_key(input logic [7:0] k, input logic [1:0] r);
        return k ^ {4{r}};
    endfunction

endpackage

// File: rtl/decryption_round.sv
// One combinational decryption round: undoes a rotate-left-by-one, then strips the round key.
module decryption_round
    import cipher_pkg::*;
(
    input  logic [7:0] x_i,
    input  logic [7:0] k_i,
    input  logic [1:0] r_i,
    output logic [7:0] x_o
);

    assign x_o = {x_i[0], x_i[7:1]} ^ round_key(k_i, r_i);

endmodule

// File: rtl/decryption.sv
// Iterative four-round character decryption: IDLE -> ROUND (r=3..0) -> DONE -> IDLE.
// Optional printable-range flag on the result is enabled by defining DECRYPTION_RANGE_CHECK_EN.
module decryption
    import cipher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [7:0] Char_ciphertext,
    input  logic [7:0] Public_key,
    output logic [7:0] Plaintext,
    output logic       P_ready,
    output logic       err_invalid_ctxt
);

    state_e     state_q, state_d;
    logic [1:0] r_q, r_d;
    logic [7:0] x_q, x_d;
    logic [7:0] k_q, k_d;
    logic [7:0] plaintext_q, plaintext_d;
    logic       p_ready_q, p_ready_d;
    logic [7:0] x_round;
    logic       last_round;

    decryption_round u_round (
        .x_i (x_q),
        .k_i (k_q),
        .r_i (r_q),
        .x_o (x_round)
    );

    assign last_round = (state_q == ROUND) && (r_q == 2'd0);

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        x_d         = x_q;
        k_d         = k_q;
        plaintext_d = plaintext_q;
        p_ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode == MODE_DEC) begin
                    x_d     = Char_ciphertext;
                    k_d     = Public_key;
                    r_d     = 2'(NUM_ROUNDS - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                x_d = x_round;
                r_d = r_q - 2'd1;
                if (r_q == 2'd0) begin
                    plaintext_d = x_round;
                    p_ready_d   = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= 2'd0;
            x_q         <= 8'h00;
            k_q         <= 8'h00;
            plaintext_q <= 8'h00;
            p_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            x_q         <= x_d;
            k_q         <= k_d;
            plaintext_q <= plaintext_d;
            p_ready_q   <= p_ready_d;
        end
    end

`ifdef DECRYPTION_RANGE_CHECK_EN
    logic err_q, err_d;

    // Flag is refreshed only when a result is written, so it tracks Plaintext.
    always_comb begin
        err_d = err_q;
        if (last_round) begin
            err_d = (x_round < PRINT_MIN) || (x_round > PRINT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_invalid_ctxt = err_q;
`else
    assign err_invalid_ctxt = 1'b0;
`endif

    assign Plaintext = plaintext_q;
    assign P_ready   = p_ready_q;

endmodule

// File: tb/tb_decryption.sv
// Scoreboard bench for decryption: driver pushes expected results, a negedge monitor pops and compares.
// Expected err values follow DECRYPTION_RANGE_CHECK_EN when it is defined for the build.
module tb_decryption;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] c_in;
    logic [7:0] k_in;
    logic [7:0] pt;
    logic       p_ready;
    logic       err;

    typedef struct {
        logic [7:0] pt;
        logic       err;
        int         rdy_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

`ifdef DECRYPTION_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    decryption dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mode             (mode),
        .Char_ciphertext  (c_in),
        .Public_key       (k_in),
        .Plaintext        (pt),
        .P_ready          (p_ready),
        .err_invalid_ctxt (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_err(input logic [7:0] p);
        return RANGE_EN && ((p < 8'h20) || (p > 8'h7E));
    endfunction

    // Reference encryption: x = rotl(x ^ rk_r, 1) for r = 0..3.
    function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] kk);
        logic [7:0] x;
        logic [1:0] r;
        x = p;
        for (int i = 0; i < 4; i++) begin
            r = 2'(i);
            x = x ^ kk ^ {4{r}};
            x = {x[6:0], x[7]};
        end
        return x;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (p_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_p_ready actual=1 required=0 cycle=%0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                check8("plaintext", pt, mon_e.pt);
                check8("err_invalid_ctxt", {7'd0, err}, {7'd0, mon_e.err});
                check_int("p_ready_cycle", cyc, mon_e.rdy_cyc);
            end
        end
    end

    // Inputs are set on a negedge; the next rising edge (N) samples the start.
    task automatic start_op(input logic [7:0] c, input logic [7:0] k,
                            input logic [7:0] exp_pt, input logic exp_e, input bit push);
        @(negedge clk);
        c_in = c;
        k_in = k;
        mode = 2'b01;
        if (push) sb.push_back('{pt: exp_pt, err: exp_e, rdy_cyc: cyc + 5});
        @(negedge clk);
        mode = 2'b00;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] p;
        logic [7:0] kk;

        rst_n = 1'b0;
        mode  = 2'b00;
        c_in  = 8'h00;
        k_in  = 8'h00;
        repeat (3) @(negedge clk);
        check8("reset_plaintext", pt, 8'h00);
        check8("reset_p_ready", {7'd0, p_ready}, 8'h00);
        check8("reset_err", {7'd0, err}, 8'h00);
        rst_n = 1'b1;

        start_op(8'hEB, 8'h00, 8'h41, 1'b0, 1'b1);
        wait_drain();
        check8("hold_plaintext", pt, 8'h41);

        start_op(8'h70, 8'hC8, 8'h7F, RANGE_EN, 1'b1);
        wait_drain();

        start_op(8'h00, 8'h00, 8'hFF, RANGE_EN, 1'b1);
        wait_drain();

        // Inputs disturbed during the rounds, mode left at decrypt through DONE.
        @(negedge clk);
        c_in = 8'hEB;
        k_in = 8'h00;
        mode = 2'b01;
        sb.push_back('{pt: 8'h41, err: 1'b0, rdy_cyc: cyc + 5});
        @(negedge clk);
        c_in = 8'h12;
        k_in = 8'h34;
        @(negedge clk);
        c_in = 8'h56;
        k_in = 8'h78;
        mode = 2'b11;
        @(negedge clk);
        mode = 2'b01;
        repeat (3) @(negedge clk);
        mode = 2'b00;
        wait_drain();

        // Reset two edges into an operation.
        start_op(8'h70, 8'hC8, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check8("abort_plaintext", pt, 8'h00);
        check8("abort_p_ready", {7'd0, p_ready}, 8'h00);
        check8("abort_err", {7'd0, err}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        start_op(8'h70, 8'hC8, 8'h7F, RANGE_EN, 1'b1);
        wait_drain();

        // Non-decrypt mode codes held in IDLE must never start an operation.
        c_in = 8'hEB;
        k_in = 8'h00;
        mode = 2'b10;
        repeat (8) @(negedge clk);
        mode = 2'b11;
        repeat (8) @(negedge clk);
        mode = 2'b00;
        repeat (8) @(negedge clk);
        check8("idle_plaintext_hold", pt, 8'h7F);

        for (int i = 0; i < 8; i++) begin
            p  = 8'($urandom_range(0, 255));
            kk = 8'($urandom_range(0, 255));
            start_op(enc(p, kk), kk, p, exp_err(p), 1'b1);
            wait_drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
